// File: rtl/vp_recovery_unit.sv
// rtl/vp_recovery_unit.sv - value-prediction verify and register-snapshot restore unit
// Optional hit/miss statistics outputs are enabled by defining VP_RECOVERY_STATS_EN.
module vp_recovery_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vp_issue,
    input  logic [DATA_WIDTH-1:0]          vp_pred,
    input  logic                           dc_valid,
    input  logic [DATA_WIDTH-1:0]          dc_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] snap_regs,
    output logic                           rf_we,
    output logic [4:0]                     rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic                           recover_snapshot,
    output logic                           recovery_done,
    output logic                           vp_ok,
    output logic                           busy
`ifdef VP_RECOVERY_STATS_EN
    ,
    output logic [15:0]                    hit_count,
    output logic [15:0]                    miss_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESTORE,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   pred_q;
    logic [4:0]              idx_q;
    logic                    vp_ok_q;
    logic                    pred_hit;
    logic                    pred_miss;
    logic [DATA_WIDTH-1:0]   snap_arr [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
        assign snap_arr[g] = snap_regs[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign pred_hit  = (state == ST_WAIT) && dc_valid && (dc_data == pred_q);
    assign pred_miss = (state == ST_WAIT) && dc_valid && (dc_data != pred_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (vp_issue) state_nxt = ST_WAIT;
            ST_WAIT:    if (dc_valid) state_nxt = pred_hit ? ST_IDLE : ST_RESTORE;
            ST_RESTORE: if (idx_q == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Register 0 is hardwired, so the restore walks indices 1..NUM_REGS-1 and holds at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q  <= '0;
            idx_q   <= '0;
            vp_ok_q <= 1'b0;
        end else begin
            vp_ok_q <= pred_hit;
            if (state == ST_IDLE && vp_issue) begin
                pred_q <= vp_pred;
            end
            if (pred_miss) begin
                idx_q <= 5'd1;
            end else if (state == ST_RESTORE && idx_q != LAST_IDX) begin
                idx_q <= idx_q + 5'd1;
            end
        end
    end

    // Outputs decode straight from state so an asynchronous reset silences them at once.
    assign rf_we            = (state == ST_RESTORE);
    assign rf_waddr         = rf_we ? idx_q : 5'd0;
    assign rf_wdata         = rf_we ? snap_arr[idx_q] : '0;
    assign recover_snapshot = (state == ST_RESTORE);
    assign recovery_done    = (state == ST_DONE);
    assign vp_ok            = vp_ok_q;
    assign busy             = (state != ST_IDLE);

`ifdef VP_RECOVERY_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (pred_hit && hit_q != 16'hFFFF) begin
                hit_q <= hit_q + 16'd1;
            end
            if (pred_miss && miss_q != 16'hFFFF) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_vp_recovery_unit.sv
// tb/tb_vp_recovery_unit.sv - self-checking bench for vp_recovery_unit
module tb_vp_recovery_unit;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vp_issue = 1'b0;
    logic [31:0]   vp_pred = '0;
    logic          dc_valid = 1'b0;
    logic [31:0]   dc_data = '0;
    logic [1023:0] snap_regs;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          recover_snapshot;
    logic          recovery_done;
    logic          vp_ok;
    logic          busy;
`ifdef VP_RECOVERY_STATS_EN
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
`endif

    vp_recovery_unit dut (
        .clk(clk), .rst_n(rst_n),
        .vp_issue(vp_issue), .vp_pred(vp_pred),
        .dc_valid(dc_valid), .dc_data(dc_data),
        .snap_regs(snap_regs),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .recover_snapshot(recover_snapshot), .recovery_done(recovery_done),
        .vp_ok(vp_ok), .busy(busy)
`ifdef VP_RECOVERY_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        done;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        sched[$];
    logic        m_wait = 1'b0;
    logic [31:0] m_pred = '0;
    logic        m_ok = 1'b0;
    int          m_hits = 0;
    int          m_misses = 0;
    int          n_we = 0, n_rec = 0, n_done = 0, n_ok = 0;
    logic [4:0]  first_addr = '0, last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: a pending prediction, and a queue holding the per-cycle restore schedule.
    task automatic model_step();
        if (!rst_n) begin
            sched.delete();
            m_wait = 1'b0; m_pred = '0; m_ok = 1'b0; m_hits = 0; m_misses = 0;
        end else begin
            m_ok = 1'b0;
            if (sched.size() > 0) begin
                void'(sched.pop_front());
            end else if (m_wait) begin
                if (dc_valid) begin
                    m_wait = 1'b0;
                    if (dc_data == m_pred) begin
                        m_ok = 1'b1;
                        if (m_hits < 65535) m_hits++;
                    end else begin
                        for (int i = 1; i < 32; i++)
                            sched.push_back('{addr: 5'(i), data: snap_regs[i*32 +: 32], done: 1'b0});
                        sched.push_back('{addr: 5'd0, data: 32'd0, done: 1'b1});
                        if (m_misses < 65535) m_misses++;
                    end
                end
            end else if (vp_issue) begin
                m_wait = 1'b1;
                m_pred = vp_pred;
            end
        end
    endtask

    task automatic compare_step();
        logic        e_we, e_done;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        e_we = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0;
        if (rst_n && sched.size() > 0) begin
            e_we   = !sched[0].done;
            e_done = sched[0].done;
            e_addr = sched[0].addr;
            e_data = sched[0].data;
        end
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
        chk("rf_wdata", rf_wdata, e_data);
        chk("recover_snapshot", 32'(recover_snapshot), 32'(e_we));
        chk("recovery_done", 32'(recovery_done), 32'(e_done));
        chk("vp_ok", 32'(vp_ok), 32'(rst_n && m_ok));
        chk("busy", 32'(busy), 32'(rst_n && (m_wait || sched.size() > 0)));
`ifdef VP_RECOVERY_STATS_EN
        chk("hit_count", 32'(hit_count), 32'(m_hits));
        chk("miss_count", 32'(miss_count), 32'(m_misses));
`endif
        if (rf_we) begin
            n_we++;
            if (n_we == 1) first_addr = rf_waddr;
            last_addr = rf_waddr;
            last_data = rf_wdata;
        end
        if (recover_snapshot) n_rec++;
        if (recovery_done) n_done++;
        if (vp_ok) n_ok++;
    endtask

    task automatic step(input logic iss, input logic [31:0] pred, input logic dv, input logic [31:0] dd);
        @(posedge clk);
        #2;
        vp_issue = iss; vp_pred = pred; dc_valid = dv; dc_data = dd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    int b_we, b_rec, b_done, b_ok;

    task automatic mark();
        b_we = n_we; b_rec = n_rec; b_done = n_done; b_ok = n_ok;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) snap_regs[i*32 +: 32] = 32'hA000 + 32'(i);
        fork
            forever @(posedge clk) model_step();
            forever @(negedge clk) compare_step();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rf_we", 32'(rf_we), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Hit: prediction confirmed two cycles after issue
        mark();
        step(1'b1, 32'h1234, 1'b0, '0);
        idle(1);
        step(1'b0, '0, 1'b1, 32'h1234);
        idle(4);
        chk("hit vp_ok pulses", 32'(n_ok - b_ok), 32'd1);
        chk("hit no writes", 32'(n_we - b_we), 32'd0);
        chk("hit busy low", 32'(busy), 32'd0);

        // Miss: full restore of registers 1..31
        mark();
        step(1'b1, 32'h1234, 1'b0, '0);
        idle(1);
        step(1'b0, '0, 1'b1, 32'h5678);
        idle(40);
        chk("miss write count", 32'(n_we - b_we), 32'd31);
        chk("miss recover cycles", 32'(n_rec - b_rec), 32'd31);
        chk("miss done pulses", 32'(n_done - b_done), 32'd1);
        chk("miss first addr", 32'(first_addr), 32'd1);
        chk("miss last addr", 32'(last_addr), 32'd31);
        chk("miss last data", last_data, 32'hA01F);
        chk("miss no vp_ok", 32'(n_ok - b_ok), 32'd0);

        // Coincident issue+dc in IDLE, then a second issue while waiting
        mark();
        step(1'b1, 32'h55, 1'b1, 32'h55);
        step(1'b1, 32'h99, 1'b0, '0);
        idle(3);
        step(1'b0, '0, 1'b1, 32'h55);
        idle(3);
        chk("coincident vp_ok", 32'(n_ok - b_ok), 32'd1);
        chk("coincident no writes", 32'(n_we - b_we), 32'd0);

        // Mismatch only in the top data bit, after a long wait
        mark();
        step(1'b1, 32'h8000_0000, 1'b0, '0);
        idle(6);
        chk("long wait busy", 32'(busy), 32'd1);
        step(1'b0, '0, 1'b1, 32'h0000_0000);
        idle(40);
        chk("msb miss writes", 32'(n_we - b_we), 32'd31);
        chk("msb miss done", 32'(n_done - b_done), 32'd1);

        // Reset during the 10th restore write
        mark();
        step(1'b1, 32'h1234, 1'b0, '0);
        step(1'b0, '0, 1'b1, 32'h5678);
        step(1'b0, '0, 1'b0, '0);
        begin
            int k;
            k = 0;
            while ((n_we - b_we) < 10 && k < 60) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("reached 10th write", 32'(n_we - b_we), 32'd10);
        end
        rst_n = 1'b0;
        #1;
        chk("async rst rf_we", 32'(rf_we), 32'd0);
        chk("async rst recover", 32'(recover_snapshot), 32'd0);
        chk("async rst wdata", rf_wdata, 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(3);
        chk("rst writes stopped", 32'(n_we - b_we), 32'd10);
        chk("rst no done", 32'(n_done - b_done), 32'd0);
        mark();
        step(1'b1, 32'h77, 1'b0, '0);
        step(1'b0, '0, 1'b1, 32'h77);
        idle(3);
        chk("post-rst hit", 32'(n_ok - b_ok), 32'd1);

`ifdef VP_RECOVERY_STATS_EN
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int h = 0; h < 3; h++) begin
            step(1'b1, 32'(h), 1'b0, '0);
            step(1'b0, '0, 1'b1, 32'(h));
            idle(1);
        end
        for (int m = 0; m < 2; m++) begin
            step(1'b1, 32'h1, 1'b0, '0);
            step(1'b0, '0, 1'b1, 32'h2);
            idle(35);
        end
        chk("stats hits", 32'(hit_count), 32'd3);
        chk("stats misses", 32'(miss_count), 32'd2);
        @(negedge clk);
        force dut.hit_q = 16'hFFFF;
        m_hits = 65535;
        @(posedge clk);
        #1 release dut.hit_q;
        step(1'b1, 32'h5, 1'b0, '0);
        step(1'b0, '0, 1'b1, 32'h5);
        idle(2);
        chk("stats saturate", 32'(hit_count), 32'hFFFF);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
